// File: rtl/ex_mem_stage_if.sv
// EX/MEM beat bus: valid/ready handshake plus WB/M control, rd address, ALU result, store data.
// Latency: none, wires only.
// Backpressure: master holds valid and payload until ready is seen high at a clock edge.
// Ports: valid, wb, m, rd_addr, alu_data, data driven by master; ready driven by slave.
interface ex_mem_stage_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int WB_W   = 2,
    parameter int M_W    = 2
);
    logic              valid;
    logic              ready;
    logic [WB_W-1:0]   wb;
    logic [M_W-1:0]    m;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] alu_data;
    logic [DATA_W-1:0] data;

    modport master (output valid, wb, m, rd_addr, alu_data, data, input ready);
    modport slave  (input  valid, wb, m, rd_addr, alu_data, data, output ready);
endinterface

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register with a 2-entry skid buffer, synchronous flush and bubble gating.
// Latency: 1 cycle from accept to output when the stage is empty, or holds one entry and pops.
// Backpressure: in_bus.ready = !skid_valid straight from a register, so out_bus.ready has no comb path to EX.
// Ports: clk, rst (sync, active high), flush; in_bus (slave, from EX); out_bus (master, to MEM);
//        fw / mem_read / mem_write are the gated RegWrite / MemRead / MemWrite of the head entry.
module ex_mem_stage #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int WB_W   = 2,
    parameter int M_W    = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    ex_mem_stage_if.slave  in_bus,
    ex_mem_stage_if.master out_bus,
    output logic          fw,
    output logic          mem_read,
    output logic          mem_write
);
    typedef struct packed {
        logic [WB_W-1:0]   wb;
        logic [M_W-1:0]    m;
        logic [ADDR_W-1:0] rd_addr;
        logic [DATA_W-1:0] alu_data;
        logic [DATA_W-1:0] data;
    } entry_t;

    entry_t head, skid, in_entry;
    logic   head_valid, skid_valid;
    logic   accept, pop;

    assign in_entry = '{wb: in_bus.wb, m: in_bus.m, rd_addr: in_bus.rd_addr,
                        alu_data: in_bus.alu_data, data: in_bus.data};

    assign in_bus.ready = ~skid_valid;
    assign accept       = in_bus.valid & ~skid_valid;
    assign pop          = head_valid & out_bus.ready;

    // skid_valid implies head_valid, so the skid slot is only ever filled
    // while the head is occupied and is drained into the head on a pop.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_valid <= 1'b0;
            skid_valid <= 1'b0;
            head       <= '0;
            skid       <= '0;
        end else if (flush) begin
            // Only the valids drop; payload is left as is and the
            // same-cycle input beat is swallowed.
            head_valid <= 1'b0;
            skid_valid <= 1'b0;
        end else if (!head_valid) begin
            if (accept) begin
                head       <= in_entry;
                head_valid <= 1'b1;
            end
        end else if (!skid_valid) begin
            if (accept && pop) begin
                head <= in_entry;
            end else if (accept) begin
                skid       <= in_entry;
                skid_valid <= 1'b1;
            end else if (pop) begin
                head_valid <= 1'b0;
            end
        end else if (pop) begin
            head       <= skid;
            skid_valid <= 1'b0;
        end
    end

    // Control fields are forced to zero on a bubble so MEM never sees a
    // stale RegWrite/MemRead/MemWrite; datapath fields show the head as is.
    assign out_bus.valid    = head_valid;
    assign out_bus.wb       = head_valid ? head.wb : '0;
    assign out_bus.m        = head_valid ? head.m  : '0;
    assign out_bus.rd_addr  = head.rd_addr;
    assign out_bus.alu_data = head.alu_data;
    assign out_bus.data     = head.data;

    assign fw        = head_valid & head.wb[0];
    assign mem_read  = head_valid & head.m[0];
    assign mem_write = head_valid & head.m[1];
endmodule

// File: tb/tb_ex_mem_stage.sv
// Bench for ex_mem_stage: directed scenarios plus random traffic against a queue-based model.
// Latency: model treats the stage as a 2-deep FIFO whose head shows the cycle after acceptance.
// Backpressure: model accepts only while fewer than two beats were held at the start of the cycle.
module tb_ex_mem_stage;
    typedef struct packed {
        logic [1:0]  wb;
        logic [1:0]  m;
        logic [4:0]  rd_addr;
        logic [31:0] alu_data;
        logic [31:0] data;
    } beat_t;

    logic clk = 1'b0;
    logic rst, flush;
    logic fw, mem_read, mem_write;

    ex_mem_stage_if #(.DATA_W(32), .ADDR_W(5), .WB_W(2), .M_W(2)) in_bus ();
    ex_mem_stage_if #(.DATA_W(32), .ADDR_W(5), .WB_W(2), .M_W(2)) out_bus ();

    ex_mem_stage #(.DATA_W(32), .ADDR_W(5), .WB_W(2), .M_W(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_bus    (in_bus),
        .out_bus   (out_bus),
        .fw        (fw),
        .mem_read  (mem_read),
        .mem_write (mem_write)
    );

    always #5 clk = ~clk;

    // Scoreboard: beats the stage should currently hold, oldest first.
    beat_t exp_q[$];
    beat_t last_head;
    bit    pops_pending;
    bit    mon_en;
    int    n_checks;
    int    n_pass;
    int    n_held;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, req, $time);
    endtask

    // Monitor: compares DUT outputs with the model head every cycle.
    always @(negedge clk) begin
        if (mon_en) begin
            n_held = exp_q.size();
            check("in_ready",  {63'd0, in_bus.ready},  {63'd0, n_held < 2});
            check("out_valid", {63'd0, out_bus.valid}, {63'd0, n_held > 0});
            if (n_held > 0) begin
                check("wb",        {62'd0, out_bus.wb},        {62'd0, exp_q[0].wb});
                check("mem_read",  {63'd0, mem_read},          {63'd0, exp_q[0].m[0]});
                check("mem_write", {63'd0, mem_write},         {63'd0, exp_q[0].m[1]});
                check("fw",        {63'd0, fw},                {63'd0, exp_q[0].wb[0]});
                check("rd_addr",   {59'd0, out_bus.rd_addr},   {59'd0, exp_q[0].rd_addr});
                check("alu_data",  {32'd0, out_bus.alu_data},  {32'd0, exp_q[0].alu_data});
                check("data",      {32'd0, out_bus.data},      {32'd0, exp_q[0].data});
                last_head = exp_q[0];
                if (out_bus.ready) begin
                    void'(exp_q.pop_front());
                    pops_pending = 1'b1;
                end
            end else begin
                // Bubble: control must be gated, datapath keeps the last head.
                check("bubble_ctl", {57'd0, out_bus.wb, out_bus.m, fw, mem_read, mem_write}, 64'd0);
                check("bubble_rd",  {59'd0, out_bus.rd_addr},  {59'd0, last_head.rd_addr});
                check("bubble_alu", {32'd0, out_bus.alu_data}, {32'd0, last_head.alu_data});
                check("bubble_dat", {32'd0, out_bus.data},     {32'd0, last_head.data});
            end
        end
    end

    // One cycle: apply inputs, let the edge happen, then update the model.
    task automatic step(input bit r, input bit f, input bit v, input bit rdy,
                        input beat_t b, output bit acc);
        rst              = r;
        flush            = f;
        in_bus.valid     = v;
        in_bus.wb        = b.wb;
        in_bus.m         = b.m;
        in_bus.rd_addr   = b.rd_addr;
        in_bus.alu_data  = b.alu_data;
        in_bus.data      = b.data;
        out_bus.ready    = rdy;
        @(posedge clk);
        acc = v && ((exp_q.size() + (pops_pending ? 1 : 0)) < 2);
        pops_pending = 1'b0;
        if (r) begin
            exp_q.delete();
            last_head = '0;
            mon_en    = 1'b1;
            acc       = 1'b0;
        end else if (f) begin
            exp_q.delete();
            acc = 1'b0;
        end else if (acc) begin
            exp_q.push_back(b);
        end
        #1;
    endtask

    task automatic idle(input bit rdy, input int n);
        bit acc;
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, rdy, '0, acc);
    endtask

    // EX side holds a beat until the model says it was taken, bounded.
    task automatic send(input beat_t b, input bit rdy);
        bit acc;
        int tries;
        acc   = 1'b0;
        tries = 0;
        while (!acc && tries < 20) begin
            step(1'b0, 1'b0, 1'b1, rdy, b, acc);
            tries++;
        end
        if (!acc) begin
            n_checks++;
            $display("FAIL send_timeout: beat 0x%0h not accepted in %0d cycles", b.alu_data, tries);
        end
    endtask

    function automatic beat_t mk(input logic [1:0] wb, input logic [1:0] m,
                                 input logic [4:0] rd, input logic [31:0] alu);
        beat_t b;
        b.wb = wb; b.m = m; b.rd_addr = rd; b.alu_data = alu; b.data = ~alu;
        return b;
    endfunction

    function automatic beat_t rnd_beat();
        beat_t b;
        b.wb       = 2'($urandom);
        b.m        = 2'($urandom);
        b.rd_addr  = 5'($urandom);
        b.alu_data = $urandom;
        b.data     = $urandom;
        return b;
    endfunction

    initial begin
        bit acc;
        n_checks = 0; n_pass = 0; pops_pending = 0; mon_en = 0; last_head = '0;

        // Reset held two cycles with a live input that must not be captured.
        step(1'b1, 1'b0, 1'b1, 1'b1, mk(2'b11, 2'b11, 5'd7, 32'hDEAD), acc);
        step(1'b1, 1'b0, 1'b1, 1'b1, mk(2'b11, 2'b11, 5'd7, 32'hDEAD), acc);
        idle(1'b1, 2);

        // Streaming, one beat per cycle.
        send(mk(2'b01, 2'b10, 5'd1, 32'h10), 1'b1);
        send(mk(2'b01, 2'b10, 5'd2, 32'h20), 1'b1);
        send(mk(2'b01, 2'b10, 5'd3, 32'h30), 1'b1);
        idle(1'b1, 2);

        // Back-pressure: fill both slots, 0xC waits, then drain in order.
        send(mk(2'b01, 2'b00, 5'd4, 32'hA), 1'b0);
        send(mk(2'b01, 2'b00, 5'd5, 32'hB), 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0, mk(2'b01, 2'b00, 5'd6, 32'hC), acc);
        send(mk(2'b01, 2'b00, 5'd6, 32'hC), 1'b1);
        idle(1'b1, 3);

        // Flush while full, with a same-cycle beat that must vanish.
        send(mk(2'b10, 2'b01, 5'd8, 32'h1), 1'b0);
        send(mk(2'b10, 2'b01, 5'd9, 32'h2), 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0, mk(2'b11, 2'b01, 5'd10, 32'h3), acc);
        idle(1'b1, 2);

        // Single beat then a bubble.
        send(mk(2'b11, 2'b11, 5'd17, 32'h55), 1'b1);
        idle(1'b1, 2);

        // Reset while full with MEM ready.
        send(mk(2'b01, 2'b10, 5'd11, 32'h77), 1'b0);
        send(mk(2'b01, 2'b10, 5'd12, 32'h88), 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b1, '0, acc);
        idle(1'b1, 2);

        // Always-valid, always-ready: behaves as a plain register.
        for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 1'b1, 1'b1, rnd_beat(), acc);

        // Random traffic with occasional flush and reset.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 99) == 0), ($urandom_range(0, 24) == 0),
                 ($urandom_range(0, 2) != 0), ($urandom_range(0, 2) != 0), rnd_beat(), acc);
        end

        idle(1'b1, 4);
        check("drained", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/ex_mem_stage.md
Name: ex_mem_stage

Overview:
- Parametrised EX/MEM pipeline register with a valid/ready handshake.
- Carries WB/M control, destination register address, ALU result and store data from EX to MEM.
- Adds a 2-entry skid buffer so MEM back-pressure can be absorbed without a combinational ready path to EX.
- Adds synchronous flush and bubble gating, so a flushed or empty slot never drives MemRead, MemWrite or RegWrite.

Parameters:
- DATA_W, 32, width of ALU result and store data.
- ADDR_W, 5, width of destination register address.
- WB_W, 2, width of write-back control field; bit 0 is RegWrite, forwarded on FW_o.
- M_W, 2, width of memory control field; bit 0 is MemRead, bit 1 is MemWrite.

Ports:
- clk_i  input  1  clock; all state updates on rising edge.
- rst_i  input  1  synchronous active-high reset.
- flush_i  input  1  discard all held entries and the same-cycle input beat.
- in_valid_i  input  1  EX presents a beat.
- in_ready_o  output  1  stage can accept a beat; registered.
- WB_i  input  WB_W  write-back control.
- M_i  input  M_W  memory control.
- RDaddr_i  input  ADDR_W  destination register.
- ALUdata_i  input  DATA_W  ALU result.
- data_i  input  DATA_W  store data (forwarded rt value).
- out_valid_o  output  1  head entry valid.
- out_ready_i  input  1  MEM consumes the head this cycle.
- WB_o  output  WB_W  head WB control, gated by out_valid_o.
- FW_o  output  1  WB_o[0], gated.
- MemRead_o  output  1  head M[0], gated.
- MemWrite_o  output  1  head M[1], gated.
- RDaddr_o  output  ADDR_W  head destination register.
- ALUdata_o  output  DATA_W  head ALU result.
- data_o  output  DATA_W  head store data.

Behaviour:
- Storage:
  - Head register H (valid hv) and skid register S (valid sv).
  - Each entry holds {WB, M, RDaddr, ALUdata, data}.
- Handshakes:
  - in_ready_o = !sv, taken from the register (no combinational path from out_ready_i).
  - Accept = in_valid_i & in_ready_o.
  - Pop = hv & out_ready_i.
- States:
  - EMPTY (hv=0, sv=0), ONE (hv=1, sv=0), FULL (hv=1, sv=1). The state sv=1, hv=0 is illegal.
- Transitions (no flush):
  - EMPTY: accept -> load H, go to ONE.
  - ONE:
    - accept and pop -> load H with the input, stay in ONE.
    - accept only -> load S, go to FULL.
    - pop only -> go to EMPTY.
    - neither -> hold.
  - FULL:
    - pop -> move S into H, sv=0, go to ONE.
    - no pop -> hold. No accept is possible because in_ready_o=0.
- Latency:
  - A beat accepted in cycle N appears on the outputs in cycle N+1 if the stage was EMPTY, or ONE with a pop.
  - Order is strictly FIFO.
- Output gating:
  - WB_o, FW_o, MemRead_o and MemWrite_o are 0 whenever out_valid_o=0.
  - RDaddr_o, ALUdata_o and data_o show H contents unconditionally.
- out_valid_o = hv.
- Flush:
  - flush_i=1 at an edge -> hv=0, sv=0.
  - The same-cycle input beat is discarded even if in_ready_o=1; the handshake completes but no data is stored.
  - H/S payload registers keep their contents; only valids clear.
  - Flush has priority over accept and pop.
- Reset:
  - rst_i=1 at an edge -> hv=0, sv=0, and all payload registers zeroed.
  - After reset: out_valid_o=0, in_ready_o=1, all outputs 0.
  - Reset overrides flush and handshakes, including mid-operation in the FULL state.
- Simultaneous events:
  - Pop with no accept in FULL -> S advances to H in the same edge; in_ready_o rises the next cycle.
  - out_ready_i with hv=0 is ignored.
- Fixed-config equivalence: with in_valid_i=1 and out_ready_i=1 always, flush_i=0, the block matches a plain one-cycle EX/MEM register.
- Widths are used exactly as parametrised, with no truncation or extension.

Test Plan:
- Reset: hold rst_i 2 cycles with in_valid_i=1 -> out_valid_o=0, in_ready_o=1, ALUdata_o=0, MemWrite_o=0; the input is not captured.
- Streaming:
  - Stimulus: out_ready_i=1; send ALUdata 0x10, 0x20, 0x30 on consecutive cycles with RDaddr 1/2/3 and M=2'b10.
  - Required: each value appears exactly one cycle later, and MemWrite_o=1 for 3 cycles.
- Back-pressure:
  - Stimulus: out_ready_i=0; send 0xA then 0xB.
  - Required: state FULL, in_ready_o=0 on the following cycle, a third beat 0xC is not accepted, and the head holds 0xA.
  - Then raise out_ready_i: outputs 0xA, 0xB, 0xC in order with no loss.
- Flush in FULL:
  - Stimulus: FULL holding 0x1/0x2 with MemRead=1; assert flush_i together with in_valid_i (data 0x3).
  - Required: next cycle out_valid_o=0, MemRead_o=0, in_ready_o=1, and 0x3 never appears at the output.
- Bubble gating: after a pop to EMPTY, RDaddr_o keeps its last value while WB_o=0, FW_o=0, MemRead_o=0, MemWrite_o=0.
- Reset mid-operation: FULL, then rst_i with out_ready_i=1 -> both entries lost and all outputs 0 on the next cycle.
